// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder that reuses one CHUNK-bit ripple
// slice per clock, with valid/ready handshakes on input and output.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/a/b/cin (operand
// side); out_valid/out_ready/sum/cout (result side).
// Optional: define CHUNKED_ADDER_OVF_EN to add the signed-overflow output ovf.
module chunked_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef CHUNKED_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;

    // The single shared slice: CHUNK+1 bits wide so the MSB is the carry out.
    always_comb begin
        a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
        chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk}
                  + {{CHUNK{1'b0}}, carry_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
                carry_d = chunk_res[CHUNK];
                if (idx_q == LAST_IDX) begin
                    cout_d  = chunk_res[CHUNK];
                    idx_d   = '0;
                    state_d = DONE;
`ifdef CHUNKED_ADDER_OVF_EN
                    // Carry into the MSB is recovered as a^b^sum at that bit.
                    ovf_d = a_q[WIDTH-1] ^ b_q[WIDTH-1]
                          ^ sum_d[WIDTH-1] ^ chunk_res[CHUNK];
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed table-driven bench for chunked_adder (32/4)
// plus 8/8 and 8/1 instances exercised against an arithmetic model.
module tb_chunked_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cin, cout;
`ifdef CHUNKED_ADDER_OVF_EN
    logic        ovf;
`endif

    logic       v8, r8, c8;
    logic [7:0] a8, b8;
    logic       rdy_f, ov_f, co_f;
    logic [7:0] sum_f;
    logic       rdy_s, ov_s, co_s;
    logic [7:0] sum_s;
`ifdef CHUNKED_ADDER_OVF_EN
    logic       ovf_f, ovf_s;
`endif

    chunked_adder #(.WIDTH(32), .CHUNK(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef CHUNKED_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    chunked_adder #(.WIDTH(8), .CHUNK(8)) dut_fast (
        .clk(clk), .reset(reset),
        .in_valid(v8), .in_ready(rdy_f),
        .a(a8), .b(b8), .cin(c8),
        .out_valid(ov_f), .out_ready(r8),
        .sum(sum_f), .cout(co_f)
`ifdef CHUNKED_ADDER_OVF_EN
        , .ovf(ovf_f)
`endif
    );

    chunked_adder #(.WIDTH(8), .CHUNK(1)) dut_slow (
        .clk(clk), .reset(reset),
        .in_valid(v8), .in_ready(rdy_s),
        .a(a8), .b(b8), .cin(c8),
        .out_valid(ov_s), .out_ready(r8),
        .sum(sum_s), .cout(co_s)
`ifdef CHUNKED_ADDER_OVF_EN
        , .ovf(ovf_s)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t tbl[12];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One operation on the 32/4 instance with out_ready held high.
    task automatic run_op(input vec_t v, input string name);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
        check({name, "_in_ready"}, in_ready, 1);
        a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick;
            n++;
        end
        check({name, "_latency"}, n, 8);
        check({name, "_sum"}, sum, v.s);
        check({name, "_cout"}, cout, v.co);
`ifdef CHUNKED_ADDER_OVF_EN
        check({name, "_ovf"}, ovf, v.ov);
`endif
        tick;
        check({name, "_post_hs"}, {in_ready, out_valid, cout, sum},
              {1'b1, 1'b0, v.co, v.s});
    endtask

    // Same operands to both 8-bit instances; latencies 1 and 8.
    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        input logic c);
        int lf, ls, n;
        logic [8:0] rf, rs, model;
        lf = -1; ls = -1; rf = '0; rs = '0;
        model = {1'b0, x} + {1'b0, y} + {8'd0, c};
        a8 = x; b8 = y; c8 = c; v8 = 1'b1;
        tick;
        v8 = 1'b0;
        n = 0;
        while ((lf < 0 || ls < 0) && n < 30) begin
            tick;
            n++;
            if (ov_f && lf < 0) begin lf = n; rf = {co_f, sum_f}; end
            if (ov_s && ls < 0) begin ls = n; rs = {co_s, sum_s}; end
        end
        tick;
        check("w8c8_result", rf, model);
        check("w8c1_result", rs, model);
        check("w8_latency", {lf[7:0], ls[7:0]}, {8'd1, 8'd8});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t q[4];
        int   pi, ci, cyc, last, extra;

        tbl[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[1]  = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1};
        tbl[2]  = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
        tbl[3]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[5]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
        tbl[6]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
        tbl[7]  = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[8]  = '{32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0};
        tbl[9]  = '{32'h0FFFFFFF, 32'h00000001, 1'b0, 32'h10000000, 1'b0, 1'b0};
        tbl[10] = '{32'hDEADBEEF, 32'h01234567, 1'b0, 32'hDFD10456, 1'b0, 1'b0};
        tbl[11] = '{32'h40000000, 32'h40000000, 1'b0, 32'h80000000, 1'b0, 1'b1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        v8 = 1'b0; r8 = 1'b1; a8 = '0; b8 = '0; c8 = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        check("reset_w32", {in_ready, out_valid, cout, sum},
              {1'b1, 1'b0, 1'b0, 32'h0});
`ifdef CHUNKED_ADDER_OVF_EN
        check("reset_ovf", ovf, 0);
`endif
        check("reset_w8", {rdy_f, ov_f, co_f, sum_f, rdy_s, ov_s, co_s, sum_s},
              {1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0});

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        a = 32'd5; b = 32'd7; cin = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        pi = 0;
        while (!out_valid && pi < 50) begin
            tick;
            pi++;
        end
        check("bp_valid", {out_valid, cout, sum}, {1'b1, 1'b0, 32'd12});
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 3 == 0);
            a = 32'hFFFF0000; b = 32'h00000123; cin = 1'b1;
            tick;
            check("bp_hold", {in_ready, out_valid, cout, sum},
                  {1'b0, 1'b1, 1'b0, 32'd12});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        check("bp_release", {in_ready, out_valid, cout, sum},
              {1'b1, 1'b0, 1'b0, 32'd12});

        // Reset during the third RUN cycle.
        a = 32'hAAAAAAAA; b = 32'h55555555; cin = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_reset", {in_ready, out_valid, cout, sum},
              {1'b1, 1'b0, 1'b0, 32'h0});
        run_op(tbl[0], "after_reset");

        // Back-to-back: in_valid held high over four queued operand sets.
        q[0] = tbl[2]; q[1] = tbl[4]; q[2] = tbl[10]; q[3] = tbl[11];
        pi = 0; ci = 0; cyc = 0; last = 0;
        a = q[0].a; b = q[0].b; cin = q[0].cin; in_valid = 1'b1;
        while (ci < 4 && cyc < 200) begin
            logic acc;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check($sformatf("b2b_res%0d", ci), {cout, sum},
                      {q[ci].co, q[ci].s});
                if (ci > 0) check($sformatf("b2b_gap%0d", ci), cyc - last, 10);
                last = cyc;
                ci++;
            end
            tick;
            cyc++;
            if (acc) begin
                pi++;
                if (pi < 4) begin
                    a = q[pi].a; b = q[pi].b; cin = q[pi].cin;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_count", ci, 4);
        check("b2b_accepts", pi, 4);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) extra++;
            tick;
        end
        check("b2b_no_extra", extra, 0);

        // 8-bit sweep, boundaries 0 and 255 included.
        for (int x = 0; x < 256; x += 15) begin
            for (int y = 0; y < 256; y += 15) begin
                run8(8'(x), 8'(y), 1'b0);
                run8(8'(x), 8'(y), 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
- Multi-cycle, parametrised successor to the team's 4-bit ripple adder.
- Adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, through a ripple-carry slice that is reused every cycle. Area stays flat as WIDTH grows.
- Valid/ready handshakes on both input and output, so it can sit in the ALU datapath or a testbench pipeline without fixed-latency assumptions.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- CHUNK, 4, bits added per cycle. WIDTH must be divisible by CHUNK; elaboration fails otherwise.
- NCHUNK (localparam), WIDTH/CHUNK, cycles spent in RUN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result, a+b+cin mod 2^WIDTH.
- cout  output  1  carry-out of bit WIDTH-1.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Reset is sampled only on the rising edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, internal chunk index=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, b, cin; set carry register=cin and index=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle add chunk[index] of a and b plus the carry register.
  - Write the CHUNK-bit result into sum[index*CHUNK +: CHUNK]; the chunk carry-out updates the carry register; index increments.
  - After chunk NCHUNK-1, cout takes the final carry and the state goes to DONE.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_valid&&out_ready, go to IDLE. out_valid drops the next cycle.
- Latency: an accept at edge N gives out_valid=1 after edge N+NCHUNK. With CHUNK=WIDTH, out_valid rises one cycle after accept.
- Throughput: one operation per NCHUNK+2 cycles (accept, NCHUNK RUN cycles, DONE handshake cycle). No overlap; in_ready is 0 in RUN and DONE.
- Upper sum bits not yet computed in RUN are undefined and must not be consumed; only DONE values are guaranteed.
- After the output handshake, sum and cout keep the last result until the next operation overwrites them.
- Backpressure: DONE with out_ready=0 holds indefinitely; sum, cout and out_valid do not change.
- in_valid while busy is ignored, with no latching. The producer must hold a, b, cin until in_ready.
- Reset mid-RUN or in DONE: abort the operation immediately. All outputs return to reset values on that edge; no partial result is emitted.
- Arithmetic: unsigned modular. The carry register is 1 bit; chunk adds are CHUNK+1 bits wide, MSB = carry.

Optional Feature:
- Macro: CHUNKED_ADDER_OVF_EN.
- When defined:
  - Extra output ovf (1 bit) = signed two's-complement overflow, i.e. carry into bit WIDTH-1 XOR cout.
  - Valid only in DONE; reset value 0; held and cleared with the same rules as cout.
- When undefined: no ovf port, no extra logic; the port list is exactly as above.

Test Plan:
- WIDTH=32, CHUNK=4: a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 -> out_valid rises exactly 8 cycles after accept; sum=0x00000000, cout=1; in_ready returns 1 the cycle after the handshake.
- a=0x7FFFFFFF, b=0x00000000, cin=1 -> sum=0x80000000, cout=0; with CHUNKED_ADDER_OVF_EN, ovf=1. Then a=0x12345678, b=0x11111111, cin=0 -> sum=0x23456789, cout=0, ovf=0.
- Backpressure: complete a=5, b=7 (sum=12) with out_ready=0 for 10 cycles -> out_valid, sum, cout stable all 10 cycles; in_valid pulses in that window are ignored (in_ready=0). Then out_ready=1 -> handshake, IDLE next cycle.
- Reset mid-operation: accept a=0xAAAAAAAA, b=0x55555555, cin=1; assert reset in the 3rd RUN cycle -> next edge out_valid=0, in_ready=1, sum=0, cout=0. A fresh operation afterwards gives the correct result (0xFFFFFFFF+1 -> sum=0, cout=1).
- Parameter sweep: WIDTH=8, CHUNK=8 and WIDTH=8, CHUNK=1 over all 2^17 (a, b, cin) combinations against a reference model -> all sums/couts match. Latency is 1 and 8 cycles respectively.
- Back-to-back: in_valid held high with 4 queued operand sets, out_ready=1 -> 4 results in order, each NCHUNK+2 cycles apart, none dropped or duplicated.
